// File: rtl/npu_spm_defines.sv
//------------------------------------------------------------------------------
// npu_spm_defines
// Shared scratchpad-memory types, plus the queued request record.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package npu_spm_defines;

    localparam int SM_PROCESSING_ELEMENTS = 16;
    localparam int SM_ADDRESS_WIDTH       = 12;
    localparam int SM_DATA_WIDTH          = 32;
    localparam int SM_BYTE_MASK_WIDTH     = 4;
    localparam int SM_PIGGYBACK_DATA_LEN  = 8;

    typedef logic [SM_ADDRESS_WIDTH-1:0]   sm_address_t;
    typedef logic [SM_DATA_WIDTH-1:0]      sm_data_t;
    typedef logic [SM_BYTE_MASK_WIDTH-1:0] sm_byte_mask_t;

    typedef struct packed {
        logic                                                     is_store;
        logic [SM_PROCESSING_ELEMENTS*$bits(sm_address_t)-1:0]    addresses;
        logic [SM_PROCESSING_ELEMENTS*$bits(sm_data_t)-1:0]       write_data;
        logic [SM_PROCESSING_ELEMENTS*$bits(sm_byte_mask_t)-1:0]  byte_mask;
        logic [SM_PROCESSING_ELEMENTS-1:0]                        mask;
        logic [SM_PIGGYBACK_DATA_LEN-1:0]                         piggyback;
    } spm_request_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage; head entry visible on o_data.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW = $clog2(SIZE);

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/spm_request_buffer.sv
//------------------------------------------------------------------------------
// spm_request_buffer
// In-order request queue in front of the scratchpad; issues, bypasses zero-mask
// requests and merges both completion paths onto one response port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spm_request_buffer
    import npu_spm_defines::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   req_valid,
    output logic                                                   req_ready,
    input  logic                                                   req_is_store,
    input  logic [SM_PROCESSING_ELEMENTS*SM_ADDRESS_WIDTH-1:0]     req_addresses,
    input  logic [SM_PROCESSING_ELEMENTS*SM_DATA_WIDTH-1:0]        req_write_data,
    input  logic [SM_PROCESSING_ELEMENTS*SM_BYTE_MASK_WIDTH-1:0]   req_byte_mask,
    input  logic [SM_PROCESSING_ELEMENTS-1:0]                      req_mask,
    input  logic [SM_PIGGYBACK_DATA_LEN-1:0]                       req_piggyback,
    output logic                                                   start,
    output logic                                                   is_store,
    output logic [SM_PROCESSING_ELEMENTS*SM_ADDRESS_WIDTH-1:0]     addresses,
    output logic [SM_PROCESSING_ELEMENTS*SM_DATA_WIDTH-1:0]        write_data,
    output logic [SM_PROCESSING_ELEMENTS*SM_BYTE_MASK_WIDTH-1:0]   byte_mask,
    output logic [SM_PROCESSING_ELEMENTS-1:0]                      mask,
    output logic [SM_PIGGYBACK_DATA_LEN-1:0]                       piggyback_data,
    input  logic                                                   sm_ready,
    input  logic                                                   sm_valid,
    input  logic [SM_PROCESSING_ELEMENTS*SM_DATA_WIDTH-1:0]        sm_read_data,
    input  logic [SM_PROCESSING_ELEMENTS*SM_BYTE_MASK_WIDTH-1:0]   sm_byte_mask,
    input  logic [SM_PROCESSING_ELEMENTS-1:0]                      sm_mask,
    input  logic [SM_PIGGYBACK_DATA_LEN-1:0]                       sm_piggyback_data,
    output logic                                                   rsp_valid,
    output logic [SM_PROCESSING_ELEMENTS*SM_DATA_WIDTH-1:0]        rsp_read_data,
    output logic [SM_PROCESSING_ELEMENTS*SM_BYTE_MASK_WIDTH-1:0]   rsp_byte_mask,
    output logic [SM_PROCESSING_ELEMENTS-1:0]                      rsp_mask,
    output logic [SM_PIGGYBACK_DATA_LEN-1:0]                       rsp_piggyback,
    output logic                                                   idle
);

    localparam int                   c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0]   c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0]   c_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]   c_ZERO    = '0;

    spm_request_t                       w_enq_req;
    spm_request_t                       w_head;
    logic [$bits(spm_request_t)-1:0]    w_head_bits;
    logic                               w_empty;
    logic                               w_full;
    logic                               w_head_active;
    logic                               w_issue;
    logic                               w_bypass;
    logic                               w_sm_fwd;
    logic [c_CNT_W-1:0]                 r_outstanding;
    logic [c_CNT_W-1:0]                 r_drain;
    logic [c_CNT_W-1:0]                 w_out_next;
    logic [c_CNT_W-1:0]                 w_drain_sum;
    logic [c_CNT_W-1:0]                 w_drain_load;

    always_comb begin
        w_enq_req            = '0;
        w_enq_req.is_store   = req_is_store;
        w_enq_req.addresses  = req_addresses;
        w_enq_req.write_data = req_write_data;
        w_enq_req.byte_mask  = req_byte_mask;
        w_enq_req.mask       = req_mask;
        w_enq_req.piggyback  = req_piggyback;
    end

    sync_fifo #(
        .WIDTH ($bits(spm_request_t)),
        .SIZE  (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (req_valid),
        .i_data  (w_enq_req),
        .i_pop   (w_issue || w_bypass),
        .o_data  (w_head_bits),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_head        = spm_request_t'(w_head_bits);
    assign w_head_active = |w_head.mask;
    assign req_ready     = !w_full;

    // While draining pre-reset traffic nothing is issued, bypassed or forwarded.
    assign w_issue  = !reset && !w_empty && (r_drain == c_ZERO) && w_head_active &&
                      sm_ready && (r_outstanding < c_MAX_OUT);
    assign w_bypass = !reset && !w_empty && (r_drain == c_ZERO) && !w_head_active &&
                      (r_outstanding == c_ZERO) && !sm_valid;
    assign w_sm_fwd = !reset && sm_valid && (r_drain == c_ZERO);

    assign start          = w_issue;
    assign is_store       = w_head.is_store;
    assign addresses      = w_head.addresses;
    assign write_data     = w_head.write_data;
    assign byte_mask      = w_head.byte_mask;
    assign mask           = w_head.mask & {SM_PROCESSING_ELEMENTS{w_issue}};
    assign piggyback_data = w_head.piggyback;

    always_comb begin
        rsp_valid     = w_sm_fwd || w_bypass;
        rsp_read_data = '0;
        rsp_byte_mask = '0;
        rsp_mask      = '0;
        rsp_piggyback = '0;
        if (w_sm_fwd) begin
            rsp_read_data = sm_read_data;
            rsp_byte_mask = sm_byte_mask;
            rsp_mask      = sm_mask;
            rsp_piggyback = sm_piggyback_data;
        end else if (w_bypass) begin
            rsp_byte_mask = w_head.byte_mask;
            rsp_piggyback = w_head.piggyback;
        end
    end

    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue)  w_out_next = w_out_next + c_ONE;
        if (w_sm_fwd) w_out_next = w_out_next - c_ONE;
    end

    // Accumulating on reset keeps the count correct if reset is held several cycles.
    assign w_drain_sum  = r_drain + r_outstanding;
    assign w_drain_load = w_drain_sum - ((sm_valid && (w_drain_sum != c_ZERO)) ? c_ONE : c_ZERO);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_outstanding <= c_ZERO;
            r_drain       <= w_drain_load;
        end else begin
            r_outstanding <= w_out_next;
            if ((r_drain != c_ZERO) && sm_valid) r_drain <= r_drain - c_ONE;
        end
    end

    assign idle = w_empty && (r_outstanding == c_ZERO) && (r_drain == c_ZERO);

    a_no_orphan_response: assert property (@(posedge clock) disable iff (reset)
        !(sm_valid && (r_drain == c_ZERO) && (r_outstanding == c_ZERO)));

    a_outstanding_bound: assert property (@(posedge clock) disable iff (reset)
        r_outstanding <= c_MAX_OUT);

endmodule

`default_nettype wire

// File: tb/tb_spm_request_buffer.sv
//------------------------------------------------------------------------------
// tb_spm_request_buffer
// Directed stimulus with a queue-based reference model checked every cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spm_request_buffer;
    import npu_spm_defines::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 4;
    localparam int PE    = SM_PROCESSING_ELEMENTS;
    localparam int AW    = SM_ADDRESS_WIDTH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    spm_request_t tb_req = '0;
    logic start, is_store, idle, rsp_valid;
    logic [PE*AW-1:0] addresses;
    logic [PE*32-1:0] write_data, rsp_read_data;
    logic [PE*4-1:0]  byte_mask, rsp_byte_mask;
    logic [PE-1:0]    mask, rsp_mask;
    logic [7:0]       piggyback_data, rsp_piggyback;
    logic             sm_ready = 1'b1;
    logic             sm_valid = 1'b0;
    logic [PE*32-1:0] sm_read_data = '0;
    logic [PE*4-1:0]  sm_byte_mask = '0;
    logic [PE-1:0]    sm_mask = '0;
    logic [7:0]       sm_piggyback_data = '0;

    always #5 clock = ~clock;

    spm_request_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(tb_req.is_store), .req_addresses(tb_req.addresses),
        .req_write_data(tb_req.write_data), .req_byte_mask(tb_req.byte_mask),
        .req_mask(tb_req.mask), .req_piggyback(tb_req.piggyback),
        .start(start), .is_store(is_store), .addresses(addresses),
        .write_data(write_data), .byte_mask(byte_mask), .mask(mask),
        .piggyback_data(piggyback_data),
        .sm_ready(sm_ready), .sm_valid(sm_valid), .sm_read_data(sm_read_data),
        .sm_byte_mask(sm_byte_mask), .sm_mask(sm_mask),
        .sm_piggyback_data(sm_piggyback_data),
        .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data),
        .rsp_byte_mask(rsp_byte_mask), .rsp_mask(rsp_mask),
        .rsp_piggyback(rsp_piggyback), .idle(idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string nm, input logic [1023:0] act,
                                input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic spm_request_t make_req(input logic [7:0] tag, input logic st,
                                              input logic [15:0] m);
        spm_request_t r;
        r = '0;
        r.is_store  = st;
        r.mask      = m;
        r.piggyback = tag;
        for (int i = 0; i < PE; i++) begin
            r.addresses[i*AW +: AW]   = AW'(int'(tag) * 16 + i);
            r.write_data[i*32 +: 32]  = {tag, 8'(i), 16'hC3A5};
            r.byte_mask[i*4 +: 4]     = 4'(int'(tag) + i);
        end
        return r;
    endfunction

    // Reference model: request queue plus in-flight and drain counts.
    spm_request_t mq[$];
    int  m_out   = 0;
    int  m_drain = 0;
    bit  mdl_on  = 0;
    logic [7:0] start_log[$];
    logic [7:0] rsp_log[$];

    always @(negedge clock) begin
        spm_request_t h;
        bit have, e_start, e_byp, e_smf, e_rv, e_idle, acc;
        if (mdl_on) begin
            have    = (mq.size() > 0);
            h       = have ? mq[0] : '0;
            e_start = !reset && have && m_drain == 0 && h.mask != 0 && sm_ready && m_out < MAXO;
            e_byp   = !reset && have && m_drain == 0 && h.mask == 0 && m_out == 0 && !sm_valid;
            e_smf   = !reset && sm_valid && m_drain == 0;
            e_rv    = e_smf || e_byp;
            e_idle  = !have && m_out == 0 && m_drain == 0;
            acc     = req_valid && mq.size() < DEPTH;

            chk("req_ready", req_ready, mq.size() < DEPTH);
            chk("idle", idle, e_idle);
            chk("start", start, e_start);
            chk("mask_out", mask, e_start ? h.mask : '0);
            if (have) begin
                chk("head_is_store", is_store, h.is_store);
                chk("head_addresses", addresses, h.addresses);
                chk("head_write_data", write_data, h.write_data);
                chk("head_byte_mask", byte_mask, h.byte_mask);
                chk("head_piggyback", piggyback_data, h.piggyback);
            end
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv) begin
                chk("rsp_read_data", rsp_read_data, e_smf ? sm_read_data : '0);
                chk("rsp_byte_mask", rsp_byte_mask, e_smf ? sm_byte_mask : h.byte_mask);
                chk("rsp_mask", rsp_mask, e_smf ? sm_mask : '0);
                chk("rsp_piggyback", rsp_piggyback, e_smf ? sm_piggyback_data : h.piggyback);
            end
            if (start) start_log.push_back(piggyback_data);
            if (rsp_valid) rsp_log.push_back(rsp_piggyback);

            if (reset) begin
                m_drain = m_drain + m_out - ((sm_valid && (m_drain + m_out) > 0) ? 1 : 0);
                m_out   = 0;
                mq.delete();
            end else begin
                if (m_drain > 0 && sm_valid) m_drain--;
                m_out = m_out + (e_start ? 1 : 0) - (e_smf ? 1 : 0);
                if (e_start || e_byp) void'(mq.pop_front());
                if (acc) mq.push_back(tb_req);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input spm_request_t r, input int bound, output bit ok);
        req_valid = 1'b1;
        tb_req    = r;
        ok        = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clock);
            ok = req_ready;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic push_must(input logic [7:0] tag, input logic [15:0] m);
        bit ok;
        push(make_req(tag, tag[0], m), 20, ok);
        chk("push_accept", ok, 1'b1);
    endtask

    task automatic respond(input logic [7:0] tag, output bit rv);
        sm_valid          = 1'b1;
        sm_piggyback_data = tag;
        sm_mask           = 16'hFFFF;
        for (int i = 0; i < PE; i++) begin
            sm_read_data[i*32 +: 32] = {8'hD0, tag, 8'(i), 8'h5A};
            sm_byte_mask[i*4 +: 4]   = 4'(i);
        end
        @(negedge clock);
        rv = rsp_valid;
        @(posedge clock);
        #1;
        sm_valid          = 1'b0;
        sm_piggyback_data = '0;
        sm_mask           = '0;
        sm_read_data      = '0;
        sm_byte_mask      = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit ok, rv;
        @(posedge clock);
        #1;
        mdl_on = 1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("reset_idle", idle, 1'b1);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_start", start, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        tick();

        // Single load: start the cycle after acceptance, then complete.
        rsp_log.delete();
        push_must(8'h10, 16'hFFFF);
        @(negedge clock);
        chk("t1_start_latency", start, 1'b1);
        tick();
        chk("t1_busy", idle, 1'b0);
        respond(8'h10, rv);
        chk("t1_rsp_valid", rv, 1'b1);
        @(negedge clock);
        chk("t1_idle_after", idle, 1'b1);
        chk("t1_rsp_tag", rsp_log.size() == 1 ? rsp_log[0] : 8'hFF, 8'h10);
        tick();

        // Fill with sm_ready low, then issue in order up to the outstanding limit.
        sm_ready = 1'b0;
        start_log.delete();
        for (int t = 0; t < 4; t++) push_must(8'(t), 16'hFFFF);
        @(negedge clock);
        chk("t2_full_ready", req_ready, 1'b0);
        tick();
        push(make_req(8'h04, 1'b0, 16'hFFFF), 2, ok);
        chk("t2_fifth_rejected", ok, 1'b0);
        sm_ready = 1'b1;
        repeat (4) tick();
        for (int t = 4; t < 7; t++) push_must(8'(t), 16'h0F0F);
        repeat (3) begin
            @(negedge clock);
            chk("t4_start_held", start, 1'b0);
            tick();
        end
        respond(8'h00, rv);
        respond(8'h01, rv);
        @(negedge clock);
        chk("t4_issue_after_simul", start, 1'b1);
        tick();
        @(negedge clock);
        chk("t4_held_at_max", start, 1'b0);
        tick();
        for (int t = 2; t < 7; t++) respond(8'(t), rv);
        @(negedge clock);
        chk("t2_start_count", start_log.size(), 7);
        for (int t = 0; t < 7; t++)
            chk("t2_start_order", start_log.size() > t ? start_log[t] : 8'hFF, 8'(t));
        chk("t2_idle", idle, 1'b1);
        tick();

        // Zero-mask request waits for the two issued loads to complete.
        rsp_log.delete();
        push_must(8'h20, 16'hFFFF);
        push_must(8'h21, 16'h00F0);
        push_must(8'h22, 16'h0000);
        repeat (3) begin
            @(negedge clock);
            chk("t3_bypass_held", rsp_valid, 1'b0);
            tick();
        end
        respond(8'h20, rv);
        respond(8'h21, rv);
        @(negedge clock);
        chk("t3_bypass_valid", rsp_valid, 1'b1);
        chk("t3_bypass_mask", rsp_mask, '0);
        chk("t3_bypass_tag", rsp_piggyback, 8'h22);
        chk("t3_bypass_data", rsp_read_data, '0);
        tick();
        chk("t3_rsp_count", rsp_log.size(), 3);
        for (int t = 0; t < 3; t++)
            chk("t3_rsp_order", rsp_log.size() > t ? rsp_log[t] : 8'hFF, 8'(8'h20 + t));

        // Simultaneous enqueue and dequeue at count 3.
        sm_ready = 1'b0;
        for (int t = 0; t < 3; t++) push_must(8'(8'h30 + t), 16'hFFFF);
        sm_ready = 1'b1;
        push_must(8'h33, 16'h8001);
        sm_ready = 1'b0;
        @(negedge clock);
        chk("t5_count3_ready", req_ready, 1'b1);
        tick();
        push_must(8'h34, 16'h1234);
        @(negedge clock);
        chk("t5_count4_full", req_ready, 1'b0);
        tick();
        sm_ready = 1'b1;
        repeat (4) tick();
        for (int t = 0; t < 5; t++) respond(8'(8'h30 + t), rv);
        @(negedge clock);
        chk("t5_idle", idle, 1'b1);
        tick();

        // Reset with two in flight and three queued.
        push_must(8'h40, 16'hFFFF);
        push_must(8'h41, 16'hFFFF);
        tick();
        sm_ready = 1'b0;
        for (int t = 2; t < 5; t++) push_must(8'(8'h40 + t), 16'hFFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sm_ready = 1'b1;
        push_must(8'h45, 16'hFFFF);
        @(negedge clock);
        chk("t6_drain_no_start", start, 1'b0);
        chk("t6_drain_not_idle", idle, 1'b0);
        tick();
        respond(8'h40, rv);
        chk("t6_absorb_0", rv, 1'b0);
        respond(8'h41, rv);
        chk("t6_absorb_1", rv, 1'b0);
        @(negedge clock);
        chk("t6_start_after_drain", start, 1'b1);
        chk("t6_start_tag", piggyback_data, 8'h45);
        tick();
        respond(8'h45, rv);
        chk("t6_rsp_after_drain", rv, 1'b1);
        @(negedge clock);
        chk("t6_idle", idle, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
